// File: rtl/grain_pkg.sv
// rtl/grain_pkg.sv - shared constants and FSM state type for the grain stream controller
package grain_pkg;
    localparam int SEED_W        = 80;
    localparam int DATA_W        = 8;
    localparam int WARMUP_CYCLES = 160;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WARMUP,
        GATHER,
        WAIT_IN,
        OUT
    } grain_state_t;
endpackage

// File: rtl/grain_ks_deserializer.sv
// rtl/grain_ks_deserializer.sv - gathers serial keystream bits into a word, LSB first
module grain_ks_deserializer
    import grain_pkg::*;
#(
    parameter int DATA_W = grain_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    input  logic              ks_bit,
    output logic [DATA_W-1:0] ks_word,
    output logic              word_full
);
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_W - 1);

    logic [CW-1:0] bit_cnt;

    // Asserted on the edge that stores the final bit of the word.
    assign word_full = en && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            bit_cnt <= '0;
            ks_word <= '0;
        end else if (en) begin
            ks_word[bit_cnt] <= ks_bit;
            bit_cnt          <= word_full ? '0 : bit_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/grain_stream_ctrl.sv
// rtl/grain_stream_ctrl.sv - drives grain load/warm-up and XORs its keystream onto a byte stream
module grain_stream_ctrl #(
    parameter int SEED_W        = grain_pkg::SEED_W,
    parameter int DATA_W        = grain_pkg::DATA_W,
    parameter int WARMUP_CYCLES = grain_pkg::WARMUP_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [SEED_W-1:0] seed,
    input  logic              ks_bit,
    output logic              grain_par_load,
    output logic              grain_shift_en,
    output logic [SEED_W-1:0] grain_seed,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              done
);
    import grain_pkg::*;

    localparam int WW = (WARMUP_CYCLES > 0) ? $clog2(WARMUP_CYCLES + 1) : 1;
    localparam logic [WW-1:0] WARM_LAST = WW'((WARMUP_CYCLES > 0) ? WARMUP_CYCLES - 1 : 0);

    grain_state_t      state;
    logic [WW-1:0]     warm_cnt;
    logic [DATA_W-1:0] ks_word;
    logic              word_full;

    assign busy = (state != IDLE);

    grain_ks_deserializer #(
        .DATA_W(DATA_W)
    ) u_deser (
        .clk      (clk),
        .rst      (rst),
        .clear    (state == LOAD),
        .en       (state == GATHER),
        .ks_bit   (ks_bit),
        .ks_word  (ks_word),
        .word_full(word_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            warm_cnt       <= '0;
            grain_par_load <= 1'b0;
            grain_shift_en <= 1'b0;
            grain_seed     <= '0;
            in_ready       <= 1'b0;
            out_data       <= '0;
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            done           <= 1'b0;
        end else begin
            grain_par_load <= 1'b0;
            done           <= 1'b0;
            case (state)
                IDLE: begin
                    // A start coinciding with the done pulse is dropped.
                    if (start && !done) begin
                        grain_seed     <= seed;
                        grain_par_load <= 1'b1;
                        state          <= LOAD;
                    end
                end
                LOAD: begin
                    warm_cnt       <= '0;
                    grain_shift_en <= 1'b1;
                    state          <= (WARMUP_CYCLES == 0) ? GATHER : WARMUP;
                end
                WARMUP: begin
                    if (warm_cnt == WARM_LAST) begin
                        warm_cnt <= '0;
                        state    <= GATHER;
                    end else begin
                        warm_cnt <= warm_cnt + 1'b1;
                    end
                end
                GATHER: begin
                    if (word_full) begin
                        grain_shift_en <= 1'b0;
                        in_ready       <= 1'b1;
                        state          <= WAIT_IN;
                    end
                end
                WAIT_IN: begin
                    if (in_valid) begin
                        out_data  <= in_data ^ ks_word;
                        out_last  <= in_last;
                        out_valid <= 1'b1;
                        in_ready  <= 1'b0;
                        state     <= OUT;
                    end
                end
                OUT: begin
                    // Keystream stays frozen until the sink takes the word.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (out_last) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            grain_shift_en <= 1'b1;
                            state          <= GATHER;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_grain_stream_ctrl.sv
// tb/tb_grain_stream_ctrl.sv - scoreboard bench for grain_stream_ctrl with a keystream source model
module tb_grain_stream_ctrl;
    localparam int WARM = 4;
    localparam logic [79:0] SEED_A = 80'h0123_4567_89AB_CDEF_0011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [79:0] seed = '0;
    logic        ks_bit;
    logic        grain_par_load, grain_shift_en;
    logic [79:0] grain_seed;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0, in_last = 1'b0, in_ready;
    logic [7:0]  out_data;
    logic        out_valid, out_last;
    logic        out_ready = 1'b0;
    logic        busy, done;

    always #5 clk = ~clk;

    grain_stream_ctrl #(.SEED_W(80), .DATA_W(8), .WARMUP_CYCLES(WARM)) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed), .ks_bit(ks_bit),
        .grain_par_load(grain_par_load), .grain_shift_en(grain_shift_en), .grain_seed(grain_seed),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_last(out_last), .out_ready(out_ready),
        .busy(busy), .done(done)
    );

    // Keystream source: one bit per shift, index restarts on every load.
    bit stream [0:255];
    int ks_idx = 0;
    assign ks_bit = stream[ks_idx[7:0]];
    always @(posedge clk) begin
        if (grain_par_load) ks_idx <= 0;
        else if (grain_shift_en) ks_idx <= ks_idx + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Word k of a message = stream bits after the warm-up, 8 per word, LSB first.
    function automatic logic [7:0] exp_word(input int k);
        logic [7:0] w;
        for (int i = 0; i < 8; i++) w[i] = stream[(WARM + 8 * k + i) % 256];
        return w;
    endfunction

    typedef struct packed {
        logic [7:0] data;
        logic       last;
    } exp_t;
    exp_t exp_q[$];
    int   word_idx = 0;

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            word_idx = 0;
            exp_q.delete();
        end else begin
            if (grain_par_load) word_idx = 0;
            check("inv_load_shift", {95'd0, grain_par_load & grain_shift_en}, 96'd0);
            check("inv_ready_valid", {95'd0, in_ready & out_valid}, 96'd0);
            if (in_valid && in_ready) begin
                exp_q.push_back('{data: in_data ^ exp_word(word_idx), last: in_last});
                word_idx++;
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_unexpected: got out_data %0h with no expected word", out_data);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_data", {88'd0, out_data}, {88'd0, e.data});
                    check("sb_last", {95'd0, out_last}, {95'd0, e.last});
                end
            end
        end
    end

    task automatic fill_stream();
        for (int i = 0; i < 256; i++) stream[i] = 1'($urandom_range(0, 1));
    endtask

    logic pl_h [0:16];
    logic se_h [0:16];
    logic ir_h [0:16];

    initial begin
        int pl_cnt, se_cnt, se_first, se_last, ir_first, n, sent;
        logic acc, got, got_done;
        logic [79:0] rseed;

        // Reset with random inputs
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            start = 1'($urandom_range(0, 1));
            seed = 80'({$urandom(), $urandom(), $urandom()});
            in_valid = 1'($urandom_range(0, 1));
            in_data = 8'($urandom());
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            check("rst_outputs", {1'b0, grain_par_load, grain_shift_en, grain_seed, in_ready,
                  out_data, out_valid, out_last, busy, done}, 96'd0);
        end
        @(posedge clk); #1;
        start = 0; in_valid = 0; out_ready = 0; in_last = 0;
        rst = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("post_rst_idle", {1'b0, grain_par_load, grain_shift_en, grain_seed, in_ready,
                  out_data, out_valid, out_last, busy, done}, 96'd0);
        end

        // Load / warm-up timing, with a start reissued mid-GATHER
        fill_stream();
        stream[4] = 1; stream[5] = 0; stream[6] = 1; stream[7] = 1;
        stream[8] = 0; stream[9] = 0; stream[10] = 0; stream[11] = 0;
        @(posedge clk); #1;
        seed = SEED_A; start = 1;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            pl_h[k] = grain_par_load; se_h[k] = grain_shift_en; ir_h[k] = in_ready;
            @(posedge clk); #1;
            start = (k == 7);
            if (k == 7) seed = ~SEED_A;
        end
        start = 0;
        pl_cnt = 0; se_cnt = 0; se_first = -1; se_last = -1; ir_first = -1;
        for (int k = 0; k < 17; k++) begin
            if (pl_h[k]) pl_cnt++;
            if (se_h[k]) begin
                se_cnt++;
                if (se_first < 0) se_first = k;
                se_last = k;
            end
            if (ir_h[k] && ir_first < 0) ir_first = k;
        end
        check("par_load_count", 96'(pl_cnt), 96'd1);
        check("par_load_cycle", {95'd0, pl_h[1]}, 96'd1);
        check("shift_count", 96'(se_cnt), 96'd12);
        check("shift_first", 96'(se_first), 96'd2);
        check("shift_last", 96'(se_last), 96'd13);
        check("in_ready_latency", 96'(ir_first), 96'd14);
        check("grain_seed_held", {16'd0, grain_seed}, {16'd0, SEED_A});

        // XOR of 0xA5 with keystream 0x0D, then backpressure
        in_valid = 1; in_data = 8'hA5; in_last = 0; out_ready = 0;
        @(posedge clk); #1;
        in_valid = 0;
        @(negedge clk);
        check("xor_valid", {95'd0, out_valid}, 96'd1);
        check("xor_data", {88'd0, out_data}, 96'hA8);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_data", {88'd0, out_data}, 96'hA8);
            check("bp_shift", {95'd0, grain_shift_en}, 96'd0);
        end
        @(posedge clk); #1;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("resume_shift", {95'd0, grain_shift_en}, 96'd1);
        end
        @(negedge clk);
        check("resume_stop", {94'd0, grain_shift_en, in_ready}, 96'd1);

        // Final word of the two-word message, done pulse, start during done
        @(posedge clk); #1;
        in_valid = 1; in_data = 8'($urandom()); in_last = 1; out_ready = 1;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = in_ready;
        end
        check("last_accept_seen", {95'd0, got}, 96'd1);
        @(posedge clk); #1;
        in_valid = 0; in_last = 0;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = out_valid;
        end
        check("last_out_seen", {95'd0, got}, 96'd1);
        check("last_out_flag", {95'd0, out_last}, 96'd1);
        @(posedge clk); #1;
        start = 1; seed = ~SEED_A;
        @(negedge clk);
        check("done_pulse", {94'd0, done, busy}, 96'd2);
        @(posedge clk); #1;
        start = 0;
        @(negedge clk);
        check("done_single", {93'd0, done, busy, grain_par_load}, 96'd0);
        check("start_on_done_ignored", {16'd0, grain_seed}, {16'd0, SEED_A});
        out_ready = 0;

        // Randomized messages under random input gaps and backpressure
        for (int m = 0; m < 6; m++) begin
            fill_stream();
            rseed = 80'({$urandom(), $urandom(), $urandom()});
            n = $urandom_range(1, 4);
            @(posedge clk); #1;
            seed = rseed; start = 1;
            @(posedge clk); #1;
            start = 0;
            @(negedge clk);
            check("rand_seed", {16'd0, grain_seed}, {16'd0, rseed});
            sent = 0; got_done = 0;
            for (int c = 0; c < 400 && !got_done; c++) begin
                @(negedge clk);
                acc = in_valid && in_ready;
                if (done) got_done = 1;
                @(posedge clk); #1;
                if (acc) sent++;
                out_ready = ($urandom_range(0, 3) != 0);
                if (acc || !in_valid) begin
                    if (sent < n && $urandom_range(0, 1) == 1) begin
                        in_valid = 1; in_data = 8'($urandom()); in_last = (sent == n - 1);
                    end else begin
                        in_valid = 0; in_last = 0;
                    end
                end
            end
            check("rand_done", {95'd0, got_done}, 96'd1);
            check("rand_words", 96'(sent), 96'(n));
            in_valid = 0; in_last = 0; out_ready = 0;
        end

        // Reset in the second warm-up cycle aborts immediately
        fill_stream();
        @(posedge clk); #1;
        seed = SEED_A; start = 1;
        @(posedge clk); #1;
        start = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check("abort_in_warmup", {95'd0, grain_shift_en}, 96'd1);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("abort_stop", {94'd0, grain_shift_en, busy}, 96'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("abort_quiet", {92'd0, grain_par_load, grain_shift_en, out_valid, in_ready}, 96'd0);
        end

        check("sb_drained", 96'(exp_q.size()), 96'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/grain_stream_ctrl.md
Name: grain_stream_ctrl

Overview:
- Control and datapath stage that drives the `grain` keystream generator and consumes its serial keystream output.
- Loads an 80-bit seed and runs a configurable warm-up period with the keystream discarded.
- Then assembles keystream bits into bytes and XORs each byte with an incoming data byte.
- Input and output data use valid/ready handshakes, so the block sits between the data source/sink and `grain`.

Parameters:
- SEED_W, 80: seed width; must match the `grain` registers.
- DATA_W, 8: bits per data word (keystream bits gathered per word).
- WARMUP_CYCLES, 160: shift cycles with keystream discarded after load; 0 is legal and skips warm-up.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a message; ignored while busy=1.
- seed  in  SEED_W  seed, sampled in the cycle start=1 is accepted.
- ks_bit  in  1  keystream bit from `grain` `out`; valid in any cycle.
- grain_par_load  out  1  drives `grain` Par_load.
- grain_shift_en  out  1  drives `grain` shift_en.
- grain_seed  out  SEED_W  drives `grain` Seed; the latched seed.
- in_data  in  DATA_W  plaintext/ciphertext byte.
- in_valid  in  1  in_data valid.
- in_last  in  1  marks the final byte of the message; qualified by in_valid.
- in_ready  out  1  block accepts in_data.
- out_data  out  DATA_W  in_data XOR keystream word.
- out_valid  out  1  out_data valid.
- out_last  out  1  out_data is the final byte.
- out_ready  in  1  sink accepts out_data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on completion of the final output transfer.

Behaviour:
- Reset: all outputs 0, grain_seed 0, FSM to IDLE, all counters and the keystream register 0. Reset mid-operation aborts immediately: grain_shift_en and grain_par_load are 0 in the next cycle and nothing else is emitted.
- IDLE:
  - start=1 latches seed into grain_seed and moves to LOAD.
- LOAD:
  - grain_par_load=1 for exactly one cycle.
  - Next state is WARMUP, or GATHER if WARMUP_CYCLES=0.
- WARMUP:
  - grain_shift_en=1 for exactly WARMUP_CYCLES consecutive cycles; ks_bit is ignored.
  - Counter width is clog2(WARMUP_CYCLES+1).
  - Then go to GATHER.
- GATHER:
  - grain_shift_en=1 for exactly DATA_W consecutive cycles.
  - On each of those edges ks_bit is stored into ks_word[bit_cnt], LSB first: the first bit goes to bit 0.
  - Then go to WAIT_IN.
- WAIT_IN:
  - in_ready=1 and grain_shift_en=0.
  - On in_valid=1: register out_data=in_data^ks_word and out_last=in_last, set out_valid=1, move to OUT. in_ready drops in that same transfer cycle's successor.
- OUT:
  - out_valid=1; out_data and out_last are held stable while out_ready=0.
  - grain_shift_en=0 throughout, so keystream state is frozen under backpressure.
  - On out_ready=1: out_valid=0. If out_last=1, pulse done and go to IDLE; otherwise go to GATHER.
- Latency and throughput:
  - start to first in_ready = 2 + WARMUP_CYCLES + DATA_W cycles.
  - Steady state with no stalls: one word per DATA_W+2 cycles.
- Invariants:
  - grain_par_load and grain_shift_en are never high together.
  - in_ready and out_valid are never high together.
  - start during busy=1 has no effect; seed is not re-latched.
  - done and start in the same cycle: start is ignored; it must be reissued once busy=0.

Decomposition:
- Package grain_pkg holds:
  - the state enum (IDLE, LOAD, WARMUP, GATHER, WAIT_IN, OUT);
  - the constants SEED_W=80, DATA_W=8 and the default WARMUP_CYCLES=160.
- One natural sub-module, grain_ks_deserializer:
  - bit counter plus ks_word shift-in;
  - inputs: clk, rst, clear, en, ks_bit;
  - outputs: ks_word, word_full.

Test Plan:
- Reset: hold rst 3 cycles with random inputs -> every output 0 and busy=0. Release -> still 0 until start.
- Load/warm-up (WARMUP_CYCLES=4): start with seed=80'h0123_4567_89AB_CDEF_0011 ->
  - grain_seed equals the seed;
  - grain_par_load high exactly 1 cycle, the cycle after start;
  - then grain_shift_en high exactly 12 consecutive cycles;
  - in_ready rises 14 cycles after start.
- XOR: ks_bit sequence 1,0,1,1,0,0,0,0 in GATHER -> ks_word=0x0D. in_data=0xA5 -> out_data=0xA8, out_valid=1 one cycle after the accept.
- Backpressure: out_ready=0 for 5 cycles -> out_data stays 0xA8, grain_shift_en stays 0. out_ready=1 -> GATHER resumes with grain_shift_en high for the next 8 cycles.
- Two-word message: in_last=1 on the second word ->
  - the second output has out_last=1;
  - done pulses exactly 1 cycle after that output transfer;
  - busy=0 on the following cycle.
- Abort/ignore:
  - rst asserted in WARMUP cycle 2 -> grain_shift_en=0 and busy=0 the next cycle.
  - start reasserted while in GATHER -> grain_seed unchanged and no second grain_par_load.
